// File: rtl/dmr_instr_fork_join_if.sv
// Upstream fetch port plus the forked replica request/response bundle.
// slave is the fork/join block's view, master the requester/replica side.
interface dmr_instr_fork_join_if #(
  parameter int NUM_OUT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic                         req_valid_i;
  logic                         req_ready_o;
  logic [AW-1:0]                req_addr_i;
  logic                         rsp_valid_o;
  logic [DW-1:0]                rsp_data_o;
  logic                         rsp_err_o;
  logic [NUM_OUT-1:0]           mem_req_valid_o;
  logic [NUM_OUT-1:0]           mem_req_ready_i;
  logic [AW-1:0]                mem_req_addr_o;
  logic [NUM_OUT-1:0]           mem_rsp_valid_i;
  logic [NUM_OUT-1:0][DW-1:0]   mem_rsp_data_i;
  logic                         error_o;

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    input  mem_req_ready_i,
    input  mem_rsp_valid_i,
    input  mem_rsp_data_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_data_o,
    output rsp_err_o,
    output mem_req_valid_o,
    output mem_req_addr_o,
    output error_o
  );

  modport master (
    output req_valid_i,
    output req_addr_i,
    output mem_req_ready_i,
    output mem_rsp_valid_i,
    output mem_rsp_data_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_data_o,
    input  rsp_err_o,
    input  mem_req_valid_o,
    input  mem_req_addr_o,
    input  error_o
  );
endinterface

// File: rtl/dmr_instr_fork_join.sv
// Forks one fetch to NUM_OUT replicas, joins and compares their responses.
// Responses may arrive in different cycles; mismatch/timeout flag an error.
module dmr_instr_fork_join #(
  parameter int NUM_OUT = 2,
  parameter int TIMEOUT = 64,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dmr_instr_fork_join_if.slave bus
);
  typedef logic [AW-1:0]      addr_t;
  typedef logic [DW-1:0]      data_t;
  typedef logic [NUM_OUT-1:0] vec_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q;
  addr_t         addr_q;
  data_t         data_q [NUM_OUT];
  vec_t          issued_q;
  vec_t          got_q;
  vec_t          stale_q;
  logic [CW-1:0] cnt_q;

  logic  busy;
  vec_t  hs;
  vec_t  issued_n;
  vec_t  acc;
  vec_t  stale_hit;
  vec_t  proto_err;
  vec_t  got_n;
  data_t data_n [NUM_OUT];
  data_t ref_data;
  logic  found;
  logic  mismatch;
  logic  all_got;
  logic  to_hit;

  assign bus.mem_req_addr_o = addr_q;

  // Classify every replica response and build the next join view.
  always_comb begin
    busy      = (state_q == ISSUE) || (state_q == WAIT);
    hs        = '0;
    if (state_q == ISSUE) begin
      hs = bus.mem_req_valid_o & bus.mem_req_ready_i;
    end
    issued_n  = issued_q | hs;
    stale_hit = bus.mem_rsp_valid_i & stale_q;
    acc       = bus.mem_rsp_valid_i & ~stale_q & issued_q
              & ~got_q & {NUM_OUT{busy}};
    proto_err = bus.mem_rsp_valid_i & ~stale_q & ~acc;
    got_n     = got_q | acc;
    for (int i = 0; i < NUM_OUT; i++) begin
      data_n[i] = acc[i] ? bus.mem_rsp_data_i[i] : data_q[i];
    end
    all_got   = &got_n;
    to_hit    = (TIMEOUT != 0) && (state_q == WAIT)
              && (cnt_q == CW'(TIMEOUT - 1)) && !all_got;
    ref_data  = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (got_n[i] && !found) begin
        ref_data = data_n[i];
        found    = 1'b1;
      end
    end
    mismatch  = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (got_n[i] && (data_n[i] != ref_data)) begin
        mismatch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q             <= IDLE;
      addr_q              <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        data_q[i] <= '0;
      end
      issued_q            <= '0;
      got_q               <= '0;
      stale_q             <= '0;
      cnt_q               <= '0;
      bus.req_ready_o     <= 1'b0;
      bus.rsp_valid_o     <= 1'b0;
      bus.rsp_data_o      <= '0;
      bus.rsp_err_o       <= 1'b0;
      bus.mem_req_valid_o <= '0;
      bus.error_o         <= 1'b0;
    end else begin
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      bus.error_o     <= |proto_err;
      stale_q         <= stale_q & ~stale_hit;
      got_q           <= got_n;
      data_q          <= data_n;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid_i && bus.req_ready_o) begin
            addr_q              <= bus.req_addr_i;
            issued_q            <= '0;
            got_q               <= '0;
            bus.req_ready_o     <= 1'b0;
            bus.mem_req_valid_o <= '1;
            state_q             <= ISSUE;
          end else begin
            bus.req_ready_o <= 1'b1;
          end
        end
        ISSUE: begin
          issued_q            <= issued_n;
          bus.mem_req_valid_o <= ~issued_n;
          if (&issued_n) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (all_got || to_hit) begin
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_data_o  <= ref_data;
            bus.rsp_err_o   <= mismatch | to_hit;
            bus.error_o     <= (|proto_err) | mismatch | to_hit;
            state_q         <= RESP;
          end
          // Missing replicas will answer later; drop that answer quietly.
          if (to_hit) begin
            stale_q <= (stale_q & ~stale_hit) | ~got_n;
          end
        end
        RESP: begin
          bus.req_ready_o <= 1'b1;
          state_q         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/dmr_instr_fork_join.md
Name: dmr_instr_fork_join

Overview:
- Memory-side counterpart of the DMR instruction fetch join.
- Takes a single, already-joined instruction fetch request and forks it to NUM_OUT redundant instruction memories or ICache replicas.
- Collects their responses, which may arrive in different cycles, and compares the fetched data.
- Returns one response upstream, with an error flag on mismatch, timeout or protocol violation.

Parameters:
- addr_t, logic, instruction address type.
- data_t, logic, instruction data type.
- NUM_OUT, 2, number of redundant replicas (>=2).
- TIMEOUT, 64, max cycles in WAIT before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- req_valid_i  in  1  upstream fetch request valid.
- req_ready_o  out  1  upstream request accepted.
- req_addr_i  in  addr_t  fetch address.
- rsp_valid_o  out  1  one-cycle response pulse; there is no upstream backpressure.
- rsp_data_o  out  data_t  response data.
- rsp_err_o  out  1  response is unreliable (mismatch or timeout), qualified by rsp_valid_o.
- mem_req_valid_o  out  NUM_OUT  per-replica request valid.
- mem_req_ready_i  in  NUM_OUT  per-replica request ready.
- mem_req_addr_o  out  addr_t  registered address, shared by all replicas.
- mem_rsp_valid_i  in  NUM_OUT  per-replica response valid, always accepted.
- mem_rsp_data_i  in  NUM_OUT x data_t  per-replica response data.
- error_o  out  1  one-cycle error pulse (mismatch, timeout, or unexpected response).

Interface decisions:
- One clock domain, clk_i.
- Reset rst_i is asynchronous and active-high.

Behaviour:
- Reset values: state IDLE.
  - req_ready_o, rsp_valid_o, rsp_err_o, error_o = 0.
  - mem_req_valid_o = 0.
  - addr_q, data_q, issued_q, got_q, stale_q, counter = '0.
  - Reset asserted mid-transaction aborts it silently: no response, no error.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, capture req_addr_i into addr_q, clear issued_q/got_q, go to ISSUE.
- ISSUE:
  - mem_req_valid_o[i] = ~issued_q[i]; mem_req_addr_o = addr_q. Valid is held until ready.
  - issued_q[i] is set on handshake.
  - Responses from already-issued replicas are captured in this state too.
  - Once all replicas are issued (including handshakes in the current cycle), go to WAIT and clear the counter.
- WAIT:
  - On mem_rsp_valid_i[i], store data_q[i] and set got_q[i].
  - Once got_q is complete, counting same-cycle arrivals, go to RESP.
  - The counter increments each cycle. If TIMEOUT != 0 and the counter == TIMEOUT-1 with responses missing:
    - set stale_q[i] for every missing replica;
    - set timeout_q;
    - go to RESP.
- RESP (one cycle, then IDLE):
  - rsp_valid_o = 1.
  - rsp_data_o = data_q of the lowest-index replica with got_q set, or '0 if none.
  - mismatch = any got_q replica's data differs from that reference data.
  - rsp_err_o = error_o = mismatch | timeout_q.
- Response classification:
  - A response from replica i with stale_q[i] set is discarded and clears stale_q[i]. It raises no error.
  - A response that is not stale, not issued, or already got, in any state, is discarded and pulses error_o the next cycle.
  - A protocol error pulse coinciding with RESP is ORed into that cycle's error_o.
- Latency:
  - Request handshake in cycle T.
  - mem_req_valid_o in T+1.
  - Earliest response in T+2 (replicas respond at least 1 cycle after handshake).
  - rsp_valid_o in the cycle after the last response (min T+3).
- Throughput: one outstanding request; req_ready_o = 0 outside IDLE.

Test Plan:
- NUM_OUT=2, all ready, both replicas respond 0xA5A5 at T+2 -> rsp_valid_o at T+3, rsp_data_o=0xA5A5, rsp_err_o=0, error_o=0.
- Replica 1 ready 3 cycles late; replica 0 responds during ISSUE -> mem_req_valid_o[0] drops after its handshake, mem_req_valid_o[1] held; single correct response; no error.
- Responses 0x1234 / 0x1235 -> rsp_data_o=0x1234, rsp_err_o=1, one-cycle error_o pulse concurrent with rsp_valid_o.
- TIMEOUT=4, replica 1 silent -> rsp_valid_o 4 cycles after entering WAIT, rsp_err_o=1, rsp_data_o=replica 0 data. Replica 1's late response during the next request is discarded without error, and that request completes correctly.
- Spurious mem_rsp_valid_i[0] in IDLE -> error_o pulse the next cycle; no rsp_valid_o; state stays IDLE.
- rst_i asserted in WAIT -> all outputs 0 asynchronously; after release req_ready_o=1 and no residual response appears.
